// File: rtl/axi_wr_rr_arbiter.sv
// Round-robin AW arbiter for one shared AXI write slave port; W follows AW grant order via a write-order FIFO.
// Optional AXI_WR_ARB_AW_REG_EN: registered one-entry AW output slice (+1 cycle AW latency).
module axi_wr_rr_arbiter #(
  parameter int NUM_MST    = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  localparam int IDX_W     = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_MST-1:0]        m_awvalid,
  output logic [NUM_MST-1:0]        m_awready,
  input  logic [NUM_MST*ADDR_W-1:0] m_awaddr,
  input  logic [NUM_MST*8-1:0]      m_awlen,
  input  logic [NUM_MST-1:0]        m_wvalid,
  output logic [NUM_MST-1:0]        m_wready,
  input  logic [NUM_MST*DATA_W-1:0] m_wdata,
  input  logic [NUM_MST-1:0]        m_wlast,
  output logic                      s_awvalid,
  input  logic                      s_awready,
  output logic [ADDR_W-1:0]         s_awaddr,
  output logic [7:0]                s_awlen,
  output logic [IDX_W-1:0]          s_awid,
  output logic                      s_wvalid,
  input  logic                      s_wready,
  output logic [DATA_W-1:0]         s_wdata,
  output logic                      s_wlast
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
  // valid never waits on ready, and a presented AW stays fixed until accepted.

  logic               r_en;
  logic [IDX_W-1:0]   r_ptr;
  logic               r_lock;
  logic [IDX_W-1:0]   r_lock_idx;
  logic [IDX_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W:0]     r_wr_ptr;
  logic [PTR_W:0]     r_rd_ptr;

  logic [IDX_W-1:0]   w_sel_hi, w_sel_lo, w_sel, w_gnt, w_head;
  logic               w_hit_hi;
  logic               w_full, w_empty;
  logic               w_up_valid, w_up_ready, w_grant, w_pop;

  always_comb begin
    w_sel_hi = '0;
    w_sel_lo = '0;
    w_hit_hi = 1'b0;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      if (m_awvalid[i]) begin
        w_sel_lo = IDX_W'(i);
        if (IDX_W'(i) >= r_ptr) begin
          w_sel_hi = IDX_W'(i);
          w_hit_hi = 1'b1;
        end
      end
    end
    w_sel = w_hit_hi ? w_sel_hi : w_sel_lo;
  end

  assign w_gnt   = r_lock ? r_lock_idx : w_sel;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

  // r_en is 0 throughout reset, so nothing is offered while rstn is low.
  assign w_up_valid = r_en & ~w_full & m_awvalid[w_gnt];
  assign w_grant    = w_up_valid & w_up_ready;

  always_comb begin
    m_awready        = '0;
    m_awready[w_gnt] = w_grant;
  end

`ifdef AXI_WR_ARB_AW_REG_EN
  logic              r_aw_vld;
  logic [ADDR_W-1:0] r_aw_addr;
  logic [7:0]        r_aw_len;
  logic [IDX_W-1:0]  r_aw_id;

  assign w_up_ready = ~r_aw_vld | s_awready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_aw_vld  <= 1'b0;
      r_aw_addr <= '0;
      r_aw_len  <= '0;
      r_aw_id   <= '0;
    end else if (w_grant) begin
      r_aw_vld  <= 1'b1;
      r_aw_addr <= m_awaddr[w_gnt*ADDR_W +: ADDR_W];
      r_aw_len  <= m_awlen[w_gnt*8 +: 8];
      r_aw_id   <= w_gnt;
    end else if (s_awready) begin
      r_aw_vld  <= 1'b0;
    end
  end

  assign s_awvalid = r_aw_vld;
  assign s_awaddr  = r_aw_addr;
  assign s_awlen   = r_aw_len;
  assign s_awid    = r_aw_id;
`else
  assign w_up_ready = s_awready;
  assign s_awvalid  = w_up_valid;
  assign s_awaddr   = w_up_valid ? m_awaddr[w_gnt*ADDR_W +: ADDR_W] : '0;
  assign s_awlen    = w_up_valid ? m_awlen[w_gnt*8 +: 8] : '0;
  assign s_awid     = w_up_valid ? w_gnt : '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_en       <= 1'b0;
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      r_en <= 1'b1;
      if (w_grant) begin
        r_lock <= 1'b0;
        r_ptr  <= (w_gnt == IDX_W'(NUM_MST - 1)) ? '0 : w_gnt + 1'b1;
      end else if (w_up_valid) begin
        // Stalled offer: freeze the choice so higher-priority arrivals cannot change it.
        r_lock     <= 1'b1;
        r_lock_idx <= w_gnt;
      end
    end
  end

  assign w_head   = r_fifo[r_rd_ptr[PTR_W-1:0]];
  assign s_wvalid = ~w_empty & m_wvalid[w_head];
  assign s_wdata  = s_wvalid ? m_wdata[w_head*DATA_W +: DATA_W] : '0;
  assign s_wlast  = s_wvalid & m_wlast[w_head];
  assign w_pop    = s_wvalid & s_wready & s_wlast;

  always_comb begin
    m_wready         = '0;
    m_wready[w_head] = s_wready & ~w_empty;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_grant) begin
        r_fifo[r_wr_ptr[PTR_W-1:0]] <= w_gnt;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule
